source_sink_arbiter: RTL and testbench
======================================

// Module: source_sink_arbiter
// PURPOSE
//  Shares one source_sink sink channel between N_SRC independent sources.
//  Each source offers bursts on a valid/ready/last interface.
//  Round-robin arbitration with burst lock; a single output register stage drives the sink.
//  Sits between the source generators and the source_sink datapath, on its clock/reset.
// PARAMETERS
//  N_SRC      4   number of requesting sources (2..16)
//  DATA_W     8   payload width per beat
//  MAX_BURST  8   max beats per grant before forced release (1..255)
// PORTS
//  clk1        in   1              system clock, rising edge
//  rst         in   1              async reset, active-low
//  src_valid   in   N_SRC          per-source beat valid
//  src_data    in   N_SRC*DATA_W   per-source payload, source i at [i*DATA_W +: DATA_W]
//  src_last    in   N_SRC          per-source last beat of burst
//  src_ready   out  N_SRC          per-source accept; only the granted bit may be 1
//  snk_valid   out  1              registered beat valid to sink
//  snk_data    out  DATA_W         registered payload
//  snk_last    out  1              registered last flag (1 also on forced release beat)
//  snk_src     out  $clog2(N_SRC)  index of source that produced current snk beat
//  snk_ready   in   1              sink accept
//  busy        out  1              1 while FSM in GRANT
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM=IDLE, rr_ptr=0, gnt=0, beat_cnt=0.
//   - snk_valid=0, snk_data=0, snk_last=0, snk_src=0, src_ready=0, busy=0.
//   - Reset mid-burst discards the output register beat; there is no recovery of a partial burst.
//  FSM IDLE:
//   - If any src_valid: gnt <= first i with src_valid at or after rr_ptr (wrapping mod N_SRC).
//   - Same edge: beat_cnt <= 0 and FSM -> GRANT. Otherwise stay in IDLE.
//  FSM GRANT:
//   - src_ready[gnt] = snk_ready | ~snk_valid (combinational); all other bits 0.
//   - Beat accepted when src_valid[gnt] & src_ready[gnt]: output reg loads data and last.
//     The loaded last = src_last[gnt] | (beat_cnt==MAX_BURST-1). snk_src <= gnt.
//   - Each accepted beat increments beat_cnt.
//   - Release on an accepted beat with loaded last=1:
//     rr_ptr <= (gnt+1) mod N_SRC, FSM -> IDLE.
//   - If the granted source drops valid mid-burst, the grant holds (no timeout).
//  Output register:
//   - Cleared (snk_valid <= 0) when snk_valid & snk_ready and no new beat is loaded.
//   - Load and drain in the same cycle -> new beat replaces the old one, so full throughput within a burst.
//   - Latency: src beat to snk_valid = 1 cycle.
//   - Arbitration gap: 1 IDLE cycle between consecutive bursts.
//  Invariants:
//   - Beats of different bursts never interleave.
//   - snk_data/snk_last/snk_src hold stable while snk_valid & ~snk_ready.
//   - src_ready=0 for every source while in IDLE.
//   - A source with no src_valid in IDLE is skipped.
//  Wrap: rr_ptr = N_SRC-1 advances to 0.
// CONFIGURATION
//  SS_ARB_STATS_EN defined:
//   - Adds output stat_beats [N_SRC*16]: per-source saturating count of accepted beats.
//   - Adds output stat_forced [16]: saturating count of MAX_BURST-forced releases.
//   - Both counters reset to 0.
//  SS_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package source_sink_pkg:
//   - typedef enum logic {IDLE, GRANT} ss_arb_state_t.
//   - Constant SS_STAT_W=16.
//  Sub-module rr_pick: combinational priority pick.
//   - Inputs req[N_SRC], ptr. Outputs idx, any.
//   - Instantiated once in this block.
// TESTING
//  T1 reset: rst=0 at t=2, release t=3
//     -> all outputs 0, busy=0; first src0 valid -> gnt=0, beat seen on snk 2 edges later.
//  T2 single burst: src1 sends 3 beats A1,A2,A3(last), snk_ready=1
//     -> snk sees A1..A3 back-to-back, snk_src=1, snk_last on A3 only, then 1 IDLE cycle.
//  T3 round-robin: src0..src3 all valid, 2-beat bursts each
//     -> grant order 0,1,2,3,0; no interleaving.
//  T4 forced release: src2 streams 20 beats, last never set, MAX_BURST=8
//     -> snk_last on beats 8 and 16; other sources are granted between src2's chunks.
//  T5 backpressure: snk_ready=0 for 5 cycles mid-burst
//     -> snk_data stable, src_ready[gnt]=0, no beat lost or duplicated.
//  T6 mid-burst reset: assert rst during beat 2 of 4
//     -> outputs 0 immediately; after release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/source_sink_pkg.sv
// Shared types and constants for the source_sink arbiter slice.
package source_sink_pkg;

    typedef enum logic {IDLE, GRANT} ss_arb_state_t;

    localparam int SS_STAT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SS_STAT_W-1:0] sat_inc(input logic [SS_STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/source_sink_arbiter_rr_pick.sv
// Round-robin priority pick: first requester at or after ptr, wrapping.
module rr_pick
    import source_sink_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IW    = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int j;

    // Scan offsets from the far end down so the nearest requester wins last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_SRC) j = j - N_SRC;
            if (req[j]) begin
                idx = IW'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/source_sink_arbiter.sv
// Round-robin burst arbiter sharing one registered sink between N_SRC sources.
// Optional per-source beat and forced-release counters: SS_ARB_STATS_EN.
module source_sink_arbiter
    import source_sink_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    input  logic [N_SRC-1:0]           src_last,
    output logic [N_SRC-1:0]           src_ready,
    output logic                       snk_valid,
    output logic [DATA_W-1:0]          snk_data,
    output logic                       snk_last,
    output logic [$clog2(N_SRC)-1:0]   snk_src,
    input  logic                       snk_ready,
    output logic                       busy
`ifdef SS_ARB_STATS_EN
    ,
    output logic [N_SRC*SS_STAT_W-1:0] stat_beats,
    output logic [SS_STAT_W-1:0]       stat_forced
`endif
);

    localparam int IW = $clog2(N_SRC);

    ss_arb_state_t state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt;
    logic [7:0]    beat_cnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          ready_gnt;
    logic          accept;
    logic          at_max;
    logic          load_last;

    rr_pick #(.N_SRC(N_SRC), .IW(IW)) u_pick (
        .req (src_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The output stage can take a beat when empty or draining this cycle.
    assign ready_gnt = snk_ready | ~snk_valid;
    assign at_max    = (beat_cnt == 8'(MAX_BURST - 1));
    assign load_last = src_last[gnt] | at_max;
    assign busy      = (state == GRANT);

    // Next-state, per-source ready and beat acceptance.
    always_comb begin
        state_nxt = state;
        src_ready = '0;
        accept    = 1'b0;
        if (state == IDLE) begin
            if (pick_any) state_nxt = GRANT;
        end else begin
            src_ready[gnt] = ready_gnt;
            accept         = src_valid[gnt] & ready_gnt;
            if (accept && load_last) state_nxt = IDLE;
        end
    end

    // State register, grant capture, burst length and round-robin pointer.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (pick_any) begin
                    gnt      <= pick_idx;
                    beat_cnt <= '0;
                end
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (load_last)
                    rr_ptr <= (gnt == IW'(N_SRC - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

    // Output register: a new beat overwrites a draining one for full throughput.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            snk_valid <= 1'b0;
            snk_data  <= '0;
            snk_last  <= 1'b0;
            snk_src   <= '0;
        end else if (accept) begin
            snk_valid <= 1'b1;
            snk_data  <= src_data[gnt*DATA_W +: DATA_W];
            snk_last  <= load_last;
            snk_src   <= gnt;
        end else if (snk_valid && snk_ready) begin
            snk_valid <= 1'b0;
        end
    end

`ifdef SS_ARB_STATS_EN
    // Saturating counters of accepted beats per source and of length-forced releases.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            stat_beats  <= '0;
            stat_forced <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (gnt == IW'(i))
                    stat_beats[i*SS_STAT_W +: SS_STAT_W] <=
                        sat_inc(stat_beats[i*SS_STAT_W +: SS_STAT_W]);
            end
            if (at_max && !src_last[gnt])
                stat_forced <= sat_inc(stat_forced);
        end
    end
`endif

endmodule

// File: tb/tb_source_sink_arbiter.sv
// Directed bench for source_sink_arbiter (N_SRC=4, DATA_W=8, MAX_BURST=8).
module tb_source_sink_arbiter;

    logic        clk1;
    logic        rst;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_last;
    logic [3:0]  src_ready;
    logic        snk_valid;
    logic [7:0]  snk_data;
    logic        snk_last;
    logic [1:0]  snk_src;
    logic        snk_ready;
    logic        busy;
`ifdef SS_ARB_STATS_EN
    logic [63:0] stat_beats;
    logic [15:0] stat_forced;
`endif

    source_sink_arbiter #(.N_SRC(4), .DATA_W(8), .MAX_BURST(8)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .snk_valid (snk_valid),
        .snk_data  (snk_data),
        .snk_last  (snk_last),
        .snk_src   (snk_src),
        .snk_ready (snk_ready),
        .busy      (busy)
`ifdef SS_ARB_STATS_EN
        ,
        .stat_beats  (stat_beats),
        .stat_forced (stat_forced)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;
    typedef beat_t beat_q_t[$];

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [1:0] s;
        int         cyc;
    } snk_rec_t;

    beat_q_t  srcq[4];
    snk_rec_t log_q[$];
    int       cyc;
    int       n_vec;
    int       n_miss;

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0) begin
                src_valid[i]       = 1'b1;
                src_data[i*8 +: 8] = srcq[i][0].d;
                src_last[i]        = srcq[i][0].l;
            end else begin
                src_valid[i]       = 1'b0;
                src_data[i*8 +: 8] = 8'h00;
                src_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        srcq[s].push_back(b);
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) srcq[i].delete();
    endtask

    // One clock: sample handshakes on the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [3:0] pops;
        snk_rec_t   r;
        @(negedge clk1);
        if (snk_valid && snk_ready) begin
            r.d   = snk_data;
            r.l   = snk_last;
            r.s   = snk_src;
            r.cyc = cyc;
            log_q.push_back(r);
        end
        pops = src_valid & src_ready;
        cyc++;
        @(posedge clk1);
        #1;
        for (int i = 0; i < 4; i++)
            if (pops[i]) void'(srcq[i].pop_front());
        drive();
    endtask

    task automatic run_until(input int n, input string tag);
        int budget;
        budget = 300;
        while (log_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check_val({tag, ".count"}, log_q.size(), n);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [7:0] d,
                             input logic l, input logic [1:0] s);
        if (idx >= log_q.size()) begin
            check_val($sformatf("%s[%0d].present", tag, idx), log_q.size(), idx + 1);
        end else begin
            check_val($sformatf("%s[%0d].data", tag, idx), log_q[idx].d, d);
            check_val($sformatf("%s[%0d].last", tag, idx), log_q[idx].l, l);
            check_val($sformatf("%s[%0d].src",  tag, idx), log_q[idx].s, s);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        clear_srcs();
        drive();
        log_q.delete();
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        cyc       = 0;
        rst       = 1'b1;
        snk_ready = 1'b1;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;

        // T1 reset
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_val("t1.snk_valid", snk_valid, 0);
        check_val("t1.snk_data",  snk_data,  0);
        check_val("t1.snk_last",  snk_last,  0);
        check_val("t1.snk_src",   snk_src,   0);
        check_val("t1.src_ready", src_ready, 0);
        check_val("t1.busy",      busy,      0);
        @(posedge clk1);
        #1;
        push(0, 8'h10, 1'b1);
        drive();
        tick();
        check_val("t1.busy_grant",  busy,      1);
        check_val("t1.ready_gnt0",  src_ready, 4'b0001);
        check_val("t1.no_beat_yet", snk_valid, 0);
        tick();
        check_val("t1.snk_valid2", snk_valid, 1);
        check_val("t1.snk_data2",  snk_data,  8'h10);
        check_val("t1.snk_src2",   snk_src,   0);
        check_val("t1.snk_last2",  snk_last,  1);
        check_val("t1.busy_rel",   busy,      0);
        tick();
        check_val("t1.drained", snk_valid, 0);
        log_q.delete();

        // T2 single burst from src1
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        drive();
        run_until(3, "t2");
        check_log("t2", 0, 8'hA1, 1'b0, 2'd1);
        check_log("t2", 1, 8'hA2, 1'b0, 2'd1);
        check_log("t2", 2, 8'hA3, 1'b1, 2'd1);
        if (log_q.size() >= 3) begin
            check_val("t2.b2b_01", log_q[1].cyc - log_q[0].cyc, 1);
            check_val("t2.b2b_12", log_q[2].cyc - log_q[1].cyc, 1);
        end
        tick();
        check_val("t2.idle_after", busy, 0);

        // T3 round-robin over all sources from rr_ptr=0
        pulse_reset();
        push(0, 8'h00, 1'b0); push(0, 8'h01, 1'b1);
        push(0, 8'h08, 1'b0); push(0, 8'h09, 1'b1);
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
        drive();
        run_until(10, "t3");
        check_log("t3", 0, 8'h00, 1'b0, 2'd0);
        check_log("t3", 1, 8'h01, 1'b1, 2'd0);
        check_log("t3", 2, 8'h10, 1'b0, 2'd1);
        check_log("t3", 3, 8'h11, 1'b1, 2'd1);
        check_log("t3", 4, 8'h20, 1'b0, 2'd2);
        check_log("t3", 5, 8'h21, 1'b1, 2'd2);
        check_log("t3", 6, 8'h30, 1'b0, 2'd3);
        check_log("t3", 7, 8'h31, 1'b1, 2'd3);
        check_log("t3", 8, 8'h08, 1'b0, 2'd0);
        check_log("t3", 9, 8'h09, 1'b1, 2'd0);
        if (log_q.size() >= 3)
            check_val("t3.arb_gap", log_q[2].cyc - log_q[1].cyc, 2);
        tick();
        log_q.delete();

        // T4 forced release: src2 streams 20 unterminated beats, rr_ptr=1
        for (int k = 0; k < 20; k++) push(2, 8'(8'h20 + k), 1'b0);
        push(3, 8'hE3, 1'b1);
        push(0, 8'hE0, 1'b1);
        drive();
        run_until(22, "t4a");
        check_val("t4.hold_busy",  busy,      1);
        check_val("t4.hold_ready", src_ready, 4'b0100);
        push(2, 8'h34, 1'b1);
        drive();
        run_until(23, "t4b");
        for (int k = 0; k < 8; k++)
            check_log("t4", k, 8'(8'h20 + k), (k == 7), 2'd2);
        check_log("t4", 8, 8'hE3, 1'b1, 2'd3);
        check_log("t4", 9, 8'hE0, 1'b1, 2'd0);
        for (int k = 0; k < 8; k++)
            check_log("t4", 10 + k, 8'(8'h28 + k), (k == 7), 2'd2);
        for (int k = 0; k < 4; k++)
            check_log("t4", 18 + k, 8'(8'h30 + k), 1'b0, 2'd2);
        check_log("t4", 22, 8'h34, 1'b1, 2'd2);
`ifdef SS_ARB_STATS_EN
        check_val("t4.stat_forced", stat_forced, 2);
`endif
        tick();
        log_q.delete();

        // T5 backpressure mid-burst from src3
        push(3, 8'h50, 1'b0);
        push(3, 8'h51, 1'b0);
        push(3, 8'h52, 1'b0);
        push(3, 8'h53, 1'b1);
        drive();
        tick();
        tick();
        tick();
        snk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("t5.stall%0d.data", k),  snk_data,  8'h51);
            check_val($sformatf("t5.stall%0d.valid", k), snk_valid, 1);
            check_val($sformatf("t5.stall%0d.ready", k), src_ready, 0);
        end
        check_val("t5.stall.src", snk_src, 3);
        snk_ready = 1'b1;
        run_until(4, "t5");
        check_log("t5", 0, 8'h50, 1'b0, 2'd3);
        check_log("t5", 1, 8'h51, 1'b0, 2'd3);
        check_log("t5", 2, 8'h52, 1'b0, 2'd3);
        check_log("t5", 3, 8'h53, 1'b1, 2'd3);
        tick();
        check_val("t5.count_final", log_q.size(), 4);
        log_q.delete();

        // T6 reset in the middle of a src2 burst (rr_ptr=2 before it)
        push(1, 8'h61, 1'b1);
        drive();
        run_until(1, "t6a");
        check_log("t6a", 0, 8'h61, 1'b1, 2'd1);
        tick();
        push(2, 8'h70, 1'b0);
        push(2, 8'h71, 1'b0);
        push(2, 8'h72, 1'b0);
        push(2, 8'h73, 1'b1);
        drive();
        tick();
        tick();
        tick();
        check_val("t6.pre_rst_data", snk_data, 8'h71);
        rst = 1'b0;
        #1;
        check_val("t6.rst_valid", snk_valid, 0);
        check_val("t6.rst_data",  snk_data,  0);
        check_val("t6.rst_last",  snk_last,  0);
        check_val("t6.rst_busy",  busy,      0);
        check_val("t6.rst_ready", src_ready, 0);
        clear_srcs();
        drive();
        #1 rst = 1'b1;
        log_q.delete();
        push(1, 8'h81, 1'b1);
        push(3, 8'h83, 1'b1);
        drive();
        run_until(2, "t6b");
        check_log("t6b", 0, 8'h81, 1'b1, 2'd1);
        check_log("t6b", 1, 8'h83, 1'b1, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
